vrased_reset_ctrl: RTL and testbench
====================================

VRASED_RESET_CTRL -- requirements
Module: vrased_reset_ctrl

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 8, minimum number of cycles sys_reset is held high per event (range 1..15).
REQ-002 SHALL have parameter RESET_HANDLER, default 16'hfffe, the PC value that completes a reset.
REQ-003 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port pc, input, 16, the current CPU program counter.
REQ-006 SHALL have port viol_atom, input, 1, violation request from the atomicity monitor.
REQ-007 SHALL have port viol_key, input, 1, violation request from the key-access monitor.
REQ-008 SHALL have port viol_dma, input, 1, violation request from the DMA monitor.
REQ-009 SHALL have port sys_reset, output, 1, registered system reset to the CPU core.
REQ-010 SHALL have port cause, output, 3, sticky cause bits {dma, key, atom} for the latest reset episode.
REQ-011 SHALL have port viol_cnt, output, 8, saturating count of reset episodes.
REQ-012 SHALL have port busy, output, 1, high when the state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, HOLD and WAIT_VEC.
REQ-014 "any_viol" SHALL be defined as viol_atom OR viol_key OR viol_dma, sampled on the clock edge.
REQ-015 In IDLE with any_viol=1, the next state SHALL be HOLD, with sys_reset=1, counter=HOLD_CYCLES-1, cause={dma,key,atom} of that cycle (previous cause discarded), and viol_cnt incremented.
REQ-016 viol_cnt SHALL saturate at 8'hff and never wrap.
REQ-017 In IDLE with any_viol=0, the block SHALL stay in IDLE with sys_reset=0, cause and viol_cnt unchanged.
REQ-018 In HOLD, sys_reset SHALL remain 1; the counter SHALL decrement each cycle; at counter=0 without any_viol, the next state SHALL be WAIT_VEC.
REQ-019 In HOLD with any_viol=1, the counter SHALL reload to HOLD_CYCLES-1, new bits SHALL be OR-ed into cause, and viol_cnt SHALL NOT change; HOLD reload takes priority over the counter=0 exit.
REQ-020 In WAIT_VEC, sys_reset SHALL remain 1 until pc==RESET_HANDLER is sampled; the next state SHALL then be IDLE with sys_reset=0 on that same edge.
REQ-021 In WAIT_VEC with any_viol=1, the next state SHALL be HOLD with counter reloaded and bits OR-ed into cause; this takes priority over pc==RESET_HANDLER and viol_cnt SHALL be unchanged.
REQ-022 Latency SHALL be one cycle: a violation sampled at edge k gives sys_reset=1 after edge k; a pulse one cycle wide SHALL suffice.
REQ-023 The minimum sys_reset width per episode SHALL be HOLD_CYCLES+1 cycles (HOLD_CYCLES in HOLD plus at least one in WAIT_VEC).
REQ-024 pc values other than RESET_HANDLER SHALL have no effect in any state.
REQ-025 busy SHALL equal (state != IDLE) and SHALL be registered consistently with sys_reset.

Reset
REQ-026 Asserting reset SHALL immediately force state=HOLD, sys_reset=1, busy=1, counter=HOLD_CYCLES-1, cause=3'b000 and viol_cnt=8'h00, so the platform boots in reset.
REQ-027 After reset is released, the sequence SHALL proceed per REQ-018/REQ-020 without incrementing viol_cnt.
REQ-028 Reset asserted mid-episode SHALL override all state and clear cause and viol_cnt.

Verification
REQ-029 Power-up: reset high 3 cycles, release, pc=16'h0000 for 20 cycles -> sys_reset=1 throughout; then pc=16'hfffe -> sys_reset=0 one edge later, cause=000, viol_cnt=0.
REQ-030 Single event: idle, viol_key pulsed 1 cycle, pc=16'hfffe held -> sys_reset=1 for exactly 9 cycles, cause=3'b010, viol_cnt=1.
REQ-031 Re-trigger: viol_atom pulse, then viol_dma pulse 5 cycles later, pc=16'hfffe -> sys_reset high 5+9=14 cycles, cause=3'b101, viol_cnt=1.
REQ-032 WAIT_VEC violation: after HOLD expires, pc=16'h1234 for 4 cycles, then viol_key and pc=16'hfffe in the same cycle -> returns to HOLD (counter=7), sys_reset stays 1, cause gains 3'b010.
REQ-033 Saturation: 260 separate episodes -> viol_cnt=8'hff; the next episode leaves it at 8'hff.
REQ-034 Async reset: assert reset mid-WAIT_VEC between clock edges -> sys_reset=1 and viol_cnt=0 without waiting for a clock edge.

Source files
------------

// File: rtl/vrased_reset_ctrl.sv
// Security reset controller: turns monitor violations into a held system reset
// that is only released once the CPU fetches the reset handler.
module vrased_reset_ctrl #(
    parameter int unsigned HOLD_CYCLES   = 8,
    parameter logic [15:0] RESET_HANDLER = 16'hfffe
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pc,
    input  logic        viol_atom,
    input  logic        viol_key,
    input  logic        viol_dma,
    output logic        sys_reset,
    output logic [2:0]  cause,
    output logic [7:0]  viol_cnt,
    output logic        busy
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned VCNT_W = 8;
    localparam logic [CNT_W-1:0]  RELOAD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [VCNT_W-1:0] VCNT_MAX = {VCNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        WAIT_VEC = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [2:0]         cause_nxt;
    logic [VCNT_W-1:0]  viol_cnt_nxt;
    logic [2:0]         viol_bits;
    logic               any_viol;

    assign viol_bits = {viol_dma, viol_key, viol_atom};
    assign any_viol  = |viol_bits;

    // State register; reset boots the platform straight into a held reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= HOLD;
            cnt       <= RELOAD;
            cause     <= 3'b000;
            viol_cnt  <= '0;
            sys_reset <= 1'b1;
            busy      <= 1'b1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            cause     <= cause_nxt;
            viol_cnt  <= viol_cnt_nxt;
            sys_reset <= (state_nxt != IDLE);
            busy      <= (state_nxt != IDLE);
        end
    end

    // Next-state logic; a fresh violation always restarts the hold window.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        cause_nxt    = cause;
        viol_cnt_nxt = viol_cnt;
        case (state)
            IDLE: begin
                if (any_viol) begin
                    state_nxt = HOLD;
                    cnt_nxt   = RELOAD;
                    cause_nxt = viol_bits;
                    if (viol_cnt != VCNT_MAX) begin
                        viol_cnt_nxt = viol_cnt + VCNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (any_viol) begin
                    cnt_nxt   = RELOAD;
                    cause_nxt = cause | viol_bits;
                end else if (cnt == '0) begin
                    state_nxt = WAIT_VEC;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            WAIT_VEC: begin
                if (any_viol) begin
                    state_nxt = HOLD;
                    cnt_nxt   = RELOAD;
                    cause_nxt = cause | viol_bits;
                end else if (pc == RESET_HANDLER) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = HOLD;
                cnt_nxt   = RELOAD;
            end
        endcase
    end

endmodule

// File: tb/tb_vrased_reset_ctrl.sv
// Directed bench for vrased_reset_ctrl: vector table plus multi-cycle episode sequences.
module tb_vrased_reset_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc;
    logic        viol_atom, viol_key, viol_dma;
    logic        sys_reset;
    logic [2:0]  cause;
    logic [7:0]  viol_cnt;
    logic        busy;

    int total = 0;
    int passed = 0;

    vrased_reset_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .viol_atom (viol_atom),
        .viol_key  (viol_key),
        .viol_dma  (viol_dma),
        .sys_reset (sys_reset),
        .cause     (cause),
        .viol_cnt  (viol_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        a, k, d;
        logic [15:0] pc;
        logic        e_sys;
        logic [2:0]  e_cause;
        logic [7:0]  e_cnt;
    } vec_t;

    vec_t tbl[16];
    int   nv = 0;

    task automatic add(input logic a, input logic k, input logic d, input logic [15:0] p,
                       input logic s, input logic [2:0] c, input logic [7:0] n);
        tbl[nv].a = a; tbl[nv].k = k; tbl[nv].d = d; tbl[nv].pc = p;
        tbl[nv].e_sys = s; tbl[nv].e_cause = c; tbl[nv].e_cnt = n;
        nv++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, then let the boot episode finish by presenting the handler address.
    task automatic boot();
        reset = 1'b1; pc = 16'h0000;
        viol_atom = 1'b0; viol_key = 1'b0; viol_dma = 1'b0;
        repeat (3) tick();
        reset = 1'b0; pc = 16'hfffe;
        for (int i = 0; i < 40 && sys_reset; i++) tick();
        chk("boot_done", 32'(sys_reset), 32'd0);
    endtask

    // Counts further high samples until sys_reset drops (bounded).
    task automatic run_low(input int budget, inout int h);
        for (int i = 0; i < budget && sys_reset; i++) begin
            tick();
            if (sys_reset) h++;
        end
    endtask

    initial begin
        int  h;
        logic all_high;
        logic sat_to;
        logic [7:0] exp_cnt;

        // Power-up
        reset = 1'b1; pc = 16'h0000;
        viol_atom = 1'b0; viol_key = 1'b0; viol_dma = 1'b0;
        #1;
        chk("rst_sys", 32'(sys_reset), 32'd1);
        chk("rst_busy", 32'(busy), 32'd1);
        repeat (3) tick();
        chk("rst_cause", 32'(cause), 32'd0);
        chk("rst_cnt", 32'(viol_cnt), 32'd0);
        reset = 1'b0;
        all_high = 1'b1;
        repeat (20) begin
            tick();
            if (!(sys_reset && busy)) all_high = 1'b0;
        end
        chk("pwr_hold_high", 32'(all_high), 32'd1);
        pc = 16'hfffe;
        tick();
        chk("pwr_rel_sys", 32'(sys_reset), 32'd0);
        chk("pwr_rel_busy", 32'(busy), 32'd0);
        chk("pwr_rel_cause", 32'(cause), 32'd0);
        chk("pwr_rel_cnt", 32'(viol_cnt), 32'd0);

        // Vector table, starting from IDLE with cause=0, viol_cnt=0
        add(0, 1, 0, 16'hfffe, 1, 3'b010, 8'd1);
        repeat (8) add(0, 0, 0, 16'hfffe, 1, 3'b010, 8'd1);
        add(0, 0, 0, 16'hfffe, 0, 3'b010, 8'd1);
        add(0, 0, 0, 16'h1234, 0, 3'b010, 8'd1);
        add(0, 0, 0, 16'hfffe, 0, 3'b010, 8'd1);
        add(1, 0, 1, 16'h0000, 1, 3'b101, 8'd2);
        add(0, 1, 0, 16'h0000, 1, 3'b111, 8'd2);
        for (int i = 0; i < nv; i++) begin
            viol_atom = tbl[i].a; viol_key = tbl[i].k; viol_dma = tbl[i].d; pc = tbl[i].pc;
            tick();
            chk($sformatf("vec%0d_sys", i), 32'(sys_reset), 32'(tbl[i].e_sys));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].e_sys));
            chk($sformatf("vec%0d_cause", i), 32'(cause), 32'(tbl[i].e_cause));
            chk($sformatf("vec%0d_cnt", i), 32'(viol_cnt), 32'(tbl[i].e_cnt));
        end
        viol_atom = 1'b0; viol_key = 1'b0; viol_dma = 1'b0;

        // Re-trigger inside HOLD: atom, then dma five cycles later
        boot();
        h = 0;
        viol_atom = 1'b1; tick(); viol_atom = 1'b0;
        if (sys_reset) h++;
        repeat (4) begin tick(); if (sys_reset) h++; end
        viol_dma = 1'b1; tick(); viol_dma = 1'b0;
        if (sys_reset) h++;
        run_low(40, h);
        chk("retrig_low", 32'(sys_reset), 32'd0);
        chk("retrig_width", 32'(h), 32'd14);
        chk("retrig_cause", 32'(cause), 32'b101);
        chk("retrig_cnt", 32'(viol_cnt), 32'd1);

        // Violation in WAIT_VEC beats the handler fetch
        boot();
        pc = 16'h1234;
        viol_atom = 1'b1; tick(); viol_atom = 1'b0;
        repeat (11) tick();
        chk("wv_still_high", 32'(sys_reset), 32'd1);
        viol_key = 1'b1; pc = 16'hfffe; tick(); viol_key = 1'b0;
        chk("wv_sys", 32'(sys_reset), 32'd1);
        chk("wv_busy", 32'(busy), 32'd1);
        chk("wv_cause", 32'(cause), 32'b011);
        chk("wv_cnt", 32'(viol_cnt), 32'd1);
        h = 1;
        run_low(40, h);
        chk("wv_reload_width", 32'(h), 32'd9);

        // Saturation of the episode counter
        boot();
        sat_to = 1'b0;
        for (int ep = 1; ep <= 261; ep++) begin
            viol_dma = 1'b1; tick(); viol_dma = 1'b0;
            h = 0;
            run_low(20, h);
            if (sys_reset) sat_to = 1'b1;
            exp_cnt = (ep > 255) ? 8'hff : 8'(ep);
            if (ep == 1 || ep == 254 || ep == 255 || ep == 260 || ep == 261)
                chk($sformatf("sat_ep%0d", ep), 32'(viol_cnt), 32'(exp_cnt));
        end
        chk("sat_timeout", 32'(sat_to), 32'd0);

        // Asynchronous reset between edges while in WAIT_VEC
        boot();
        pc = 16'h1234;
        viol_key = 1'b1; tick(); viol_key = 1'b0;
        repeat (10) tick();
        chk("arst_pre_cnt", 32'(viol_cnt), 32'd1);
        chk("arst_pre_cause", 32'(cause), 32'b010);
        #2 reset = 1'b1;
        #1;
        chk("arst_sys", 32'(sys_reset), 32'd1);
        chk("arst_busy", 32'(busy), 32'd1);
        chk("arst_cnt", 32'(viol_cnt), 32'd0);
        chk("arst_cause", 32'(cause), 32'd0);
        tick();
        reset = 1'b0;
        pc = 16'hfffe;
        h = 1;
        run_low(40, h);
        chk("arst_boot_width", 32'(h), 32'd9);
        chk("arst_boot_cnt", 32'(viol_cnt), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
